// File: rtl/quad_leaf_seq.sv
// Command sequencer for the four leaves of a quad page: drives per-leaf reset,
// ap_start and resend pulses with programmable widths, one command at a time.
module quad_leaf_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int START_CYCLES  = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_mask,
  output logic [3:0] leaf_reset,
  output logic [3:0] leaf_ap_start,
  output logic [3:0] leaf_resend,
  output logic [3:0] leaf_started,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_STRT   = 3'd3,
    S_RSND   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_START  = 2'b10;

  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LD  = CNT_W'(START_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_mask;
  logic [3:0]       r_leaf_reset;
  logic [3:0]       r_leaf_ap_start;
  logic [3:0]       r_leaf_resend;
  logic [3:0]       r_leaf_started;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;

  // Handshake: a command transfers on any edge where cmd_valid && cmd_ready;
  // ready is high only in IDLE outside reset, and nothing is queued otherwise.
  assign cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_mask          <= '0;
      r_leaf_reset    <= 4'hF;
      r_leaf_ap_start <= '0;
      r_leaf_resend   <= '0;
      r_leaf_started  <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_leaf_reset <= '0;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          if (w_accept) begin
            r_mask <= cmd_mask;
            r_busy <= 1'b1;
            if (cmd_op == OP_NOP || cmd_mask == 4'h0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (cmd_op == OP_RESET) begin
              r_state        <= S_RST;
              r_cnt          <= RST_LD;
              r_leaf_reset   <= cmd_mask;
              r_leaf_started <= r_leaf_started & ~cmd_mask;
            end else if (cmd_op == OP_START) begin
              r_state         <= S_STRT;
              r_cnt           <= START_LD;
              r_leaf_ap_start <= cmd_mask;
              r_leaf_started  <= r_leaf_started | cmd_mask;
            end else begin
              // Only leaves that were started ever see a resend.
              r_state       <= S_RSND;
              r_leaf_resend <= cmd_mask & r_leaf_started;
            end
          end
        end
        S_RST: begin
          if (r_cnt == '0) begin
            r_state      <= S_SETTLE;
            r_cnt        <= SETTLE_LD;
            r_leaf_reset <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STRT: begin
          if (r_cnt == '0) begin
            r_state         <= S_DONE;
            r_leaf_ap_start <= '0;
            r_done          <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RSND: begin
          r_state       <= S_DONE;
          r_leaf_resend <= '0;
          r_done        <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state         <= S_IDLE;
          r_leaf_reset    <= '0;
          r_leaf_ap_start <= '0;
          r_leaf_resend   <= '0;
          r_busy          <= 1'b0;
          r_done          <= 1'b0;
        end
      endcase
    end
  end

  assign leaf_reset    = r_leaf_reset;
  assign leaf_ap_start = r_leaf_ap_start;
  assign leaf_resend   = r_leaf_resend;
  assign leaf_started  = r_leaf_started;
  assign busy          = r_busy;
  assign done          = r_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_quad_leaf_seq.sv
// Bench for quad_leaf_seq: directed vector table, hand-written corner sequences
// and random commands checked cycle by cycle against a waveform model.
module tb_quad_leaf_seq;
  localparam int RST_C = 16;
  localparam int SET_C = 8;
  localparam int STA_C = 4;
  localparam int W     = 19;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [3:0] leaf_reset;
  logic [3:0] leaf_ap_start;
  logic [3:0] leaf_resend;
  logic [3:0] leaf_started;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  quad_leaf_seq #(
    .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C), .START_CYCLES(STA_C), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .leaf_reset(leaf_reset),
    .leaf_ap_start(leaf_ap_start), .leaf_resend(leaf_resend),
    .leaf_started(leaf_started), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // scoreboard: one entry per cycle, {reset, ap_start, resend, started, busy, done, ready}
  logic [W-1:0] exp_q[$];
  logic [3:0]   m_started;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] mask;
    int         lat;
    logic [3:0] started;
    logic [3:0] resend_seen;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [W-1:0] obs();
    return {leaf_reset, leaf_ap_start, leaf_resend, leaf_started, busy, done, cmd_ready};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] a, input logic [3:0] s,
                      input logic b, input logic d, input logic rdy);
    exp_q.push_back({r, a, s, m_started, b, d, rdy});
  endtask

  // Expected per-cycle outputs from acceptance+1 up to the first ready cycle.
  task automatic model_cmd(input logic [1:0] op, input logic [3:0] mask);
    if (op == 2'd0 || mask == 4'd0) begin
      push(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    end else if (op == 2'd1) begin
      m_started = m_started & ~mask;
      repeat (RST_C) push(mask, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      repeat (SET_C) push(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      push(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    end else if (op == 2'd2) begin
      m_started = m_started | mask;
      repeat (STA_C) push(4'h0, mask, 4'h0, 1'b1, 1'b0, 1'b0);
      push(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    end else begin
      push(4'h0, 4'h0, mask & m_started, 1'b1, 1'b0, 1'b0);
      push(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    end
    push(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  // driver: issue one command, then compare every cycle until ready returns
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] mask,
                         output int lat, output logic [3:0] resend_seen);
    int waitc;
    int k;
    logic [W-1:0] e;
    waitc = 0;
    lat = -1;
    resend_seen = 4'h0;
    while (!cmd_ready && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    model_cmd(op, mask);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_mask  = 4'($urandom_range(0, 15));
    k = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle", {13'd0, obs()}, {13'd0, e});
      resend_seen = resend_seen | leaf_resend;
      if (done && lat < 0) lat = k;
      if (exp_q.size() > 0) begin
        @(posedge clk); #1;
        k++;
      end
    end
  endtask

  initial begin
    int lat;
    logic [3:0] rs;
    logic [1:0] rop;
    logic [3:0] rmask;

    vecs[0] = '{2'd1, 4'h5, 25, 4'h0, 4'h0};
    vecs[1] = '{2'd2, 4'hF,  5, 4'hF, 4'h0};
    vecs[2] = '{2'd3, 4'h3,  2, 4'hF, 4'h3};
    vecs[3] = '{2'd1, 4'h1, 25, 4'hE, 4'h0};
    vecs[4] = '{2'd3, 4'hF,  2, 4'hE, 4'hE};
    vecs[5] = '{2'd0, 4'hF,  1, 4'hE, 4'h0};
    vecs[6] = '{2'd1, 4'h0,  1, 4'hE, 4'h0};
    vecs[7] = '{2'd2, 4'h0,  1, 4'hE, 4'h0};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_mask  = 4'd0;
    m_started = 4'h0;

    // reset release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {13'd0, obs()}, {13'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_outputs", {13'd0, obs()}, {13'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1});

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].op, vecs[i].mask, lat, rs);
      chk("tbl_lat", lat, vecs[i].lat);
      chk("tbl_started", {28'd0, leaf_started}, {28'd0, vecs[i].started});
      chk("tbl_resend", {28'd0, rs}, {28'd0, vecs[i].resend_seen});
    end

    // cmd_valid held high: one NOP accepted per done+1 cycles
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_mask  = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 6) cmd_valid = 1'b0;
      chk("held_done", {31'd0, done}, {31'd0, (k % 2) == 1});
      chk("held_ready", {31'd0, cmd_ready}, {31'd0, (k % 2) == 0});
      chk("held_leaves", {20'd0, leaf_reset, leaf_ap_start, leaf_resend}, 32'd0);
    end

    // random commands against the model
    for (int n = 0; n < 40; n++) begin
      rop   = 2'($urandom_range(0, 3));
      rmask = 4'($urandom_range(0, 15));
      run_cmd(rop, rmask, lat, rs);
      chk("rnd_started", {28'd0, leaf_started}, {28'd0, m_started});
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // reset in cycle 3 of a START
    run_cmd(2'd1, 4'hF, lat, rs);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_mask  = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mid_c1_start", {28'd0, leaf_ap_start}, 32'hF);
    @(posedge clk); #1;
    chk("mid_c2_start", {28'd0, leaf_ap_start}, 32'hF);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_outputs", {13'd0, obs()}, {13'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_no_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    m_started = 4'h0;
    @(posedge clk); #1;
    chk("mid_release", {13'd0, obs()}, {13'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1});
    run_cmd(2'd2, 4'h3, lat, rs);
    chk("post_lat", lat, 5);
    chk("post_started", {28'd0, leaf_started}, 32'h3);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
